// File: rtl/mips_wb_pkg.sv
// Shared types and widths for the MIPS writeback queue.
//
// Contents:
//   REG_ADDR_W  register-file address width (3)
//   DATA_W      register-file data width (32)
//   wb_entry_t  one pending write {reg_addr, data}
package mips_wb_pkg;

   localparam int REG_ADDR_W = 3;
   localparam int DATA_W     = 32;

   // "reg" is a reserved word, so the address field is named reg_addr.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] reg_addr;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

endpackage

// File: rtl/mips_wb_fifo.sv
// Storage and pointers for the writeback queue.
//
// Ports:
//   clk, rst     clock, async active-high reset (clears pointers and count)
//   push, pop    qualified by the top level; never push when full or pop when empty
//   push_entry   entry written at the tail on push
//   head         entry at the read pointer
//   entries      raw storage, exported for forwarding (MIPS_WB_FORWARD_EN only)
//   rd_ptr_out   read pointer, exported for forwarding (MIPS_WB_FORWARD_EN only)
//   count        occupancy 0..DEPTH
//
// Configuration macro: MIPS_WB_FORWARD_EN
module mips_wb_fifo
   import mips_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  wb_entry_t              push_entry,
   output wb_entry_t              head,
`ifdef MIPS_WB_FORWARD_EN
   output wb_entry_t [DEPTH-1:0]  entries,
   output logic [PTR_W-1:0]       rd_ptr_out,
`endif
   output logic [4:0]             count
);

   wb_entry_t [DEPTH-1:0] mem;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + 5'(push) - 5'(pop);
      end
   end

   // Contents need no reset: only slots inside [rd_ptr, rd_ptr+count) are ever read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   assign head = mem[rd_ptr];

`ifdef MIPS_WB_FORWARD_EN
   assign entries    = mem;
   assign rd_ptr_out = rd_ptr;
`endif

endmodule

// File: rtl/mips_writeback_queue.sv
// Writeback queue between the pipeline and a single register-file write port.
// Requests are buffered in FIFO order and drained one per cycle whenever the
// write port is not stalled; requests to register 0 are accepted and dropped.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   wb_valid/wb_ready         request handshake (ready = not full, low in reset)
//   wb_reg, wb_data           request address and data
//   stall                     write port busy; freezes the head
//   write_reg, write_data     registered write port, held between pops
//   signal_reg_write          one-cycle strobe per popped entry
//   count                     registered occupancy
//   fwd_reg_k, fwd_hit_k,
//   fwd_data_k (k = 1, 2)     forwarding lookup (MIPS_WB_FORWARD_EN only)
//
// Configuration macro: MIPS_WB_FORWARD_EN enables the forwarding ports and
// comparators; without it neither ports nor logic exist.
module mips_writeback_queue
   import mips_wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_valid,
   output logic                  wb_ready,
   input  logic [REG_ADDR_W-1:0] wb_reg,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  stall,
   output logic [REG_ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0]     write_data,
   output logic                  signal_reg_write,
`ifdef MIPS_WB_FORWARD_EN
   input  logic [REG_ADDR_W-1:0] fwd_reg_1,
   input  logic [REG_ADDR_W-1:0] fwd_reg_2,
   output logic                  fwd_hit_1,
   output logic                  fwd_hit_2,
   output logic [DATA_W-1:0]     fwd_data_1,
   output logic [DATA_W-1:0]     fwd_data_2,
`endif
   output logic [4:0]            count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic      push;
   logic      pop;
   wb_entry_t push_entry;
   wb_entry_t head;

`ifdef MIPS_WB_FORWARD_EN
   wb_entry_t [DEPTH-1:0] entries;
   logic [PTR_W-1:0]      rd_ptr;
`endif

   // Ready is gated by rst so it reads 0 throughout reset and rises as soon
   // as reset is released; it never looks at wb_valid.
   assign wb_ready   = !rst && (count != 5'(DEPTH));
   assign push       = wb_valid && wb_ready && (wb_reg != '0);
   assign pop        = (count != '0) && !stall;
   assign push_entry = '{reg_addr: wb_reg, data: wb_data};

   mips_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .push_entry (push_entry),
      .head       (head),
`ifdef MIPS_WB_FORWARD_EN
      .entries    (entries),
      .rd_ptr_out (rd_ptr),
`endif
      .count      (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_reg        <= '0;
         write_data       <= '0;
         signal_reg_write <= 1'b0;
      end else begin
         signal_reg_write <= pop;
         if (pop) begin
            write_reg  <= head.reg_addr;
            write_data <= head.data;
         end
      end
   end

`ifdef MIPS_WB_FORWARD_EN
   // Youngest match wins: the output stage is oldest, then queue entries from
   // head to tail, so later hits in the scan overwrite earlier ones.
   function automatic logic [DATA_W:0] lookup(input logic [REG_ADDR_W-1:0] addr);
      logic [DATA_W:0]  res;
      logic [PTR_W-1:0] idx;
      res = '0;
      if (addr != '0) begin
         if (signal_reg_write && (write_reg == addr))
            res = {1'b1, write_data};
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((5'(i) < count) && (entries[idx].reg_addr == addr))
               res = {1'b1, entries[idx].data};
         end
      end
      return res;
   endfunction

   always_comb begin
      {fwd_hit_1, fwd_data_1} = lookup(fwd_reg_1);
      {fwd_hit_2, fwd_data_2} = lookup(fwd_reg_2);
   end
`endif

endmodule
